// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : traffic_phase_scheduler_if                                  |
// | Brief  : Sensor inputs, grant handshake and phase-completion bundle  |
// |          between the phase scheduler and the light sequencer.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface traffic_phase_scheduler_if #(
  parameter int CW = 11
);
  logic [1:0]    sensor_north;
  logic [1:0]    sensor_east;
  logic [1:0]    sensor_south;
  logic [1:0]    sensor_west;
  logic          grant_ready;
  logic          phase_done;
  logic          grant_valid;
  logic [1:0]    grant_dir;
  logic [CW-1:0] grant_green;
  logic          grant_starved;
  logic          busy;

  // Scheduler side: issues grants, consumes sensors and sequencer feedback
  modport master (
    input  sensor_north, sensor_east, sensor_south, sensor_west,
    input  grant_ready, phase_done,
    output grant_valid, grant_dir, grant_green, grant_starved, busy
  );

  // Sequencer / environment side
  modport slave (
    output sensor_north, sensor_east, sensor_south, sensor_west,
    output grant_ready, phase_done,
    input  grant_valid, grant_dir, grant_green, grant_starved, busy
  );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : traffic_phase_scheduler                                     |
// | Brief  : Chooses the next green approach (N/E/S/W) from traffic      |
// |          level, starvation age and round-robin order, sizes the      |
// |          green time and offers it over a valid/ready handshake.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module traffic_phase_scheduler #(
  parameter int BASE_GREEN = 100,
  parameter int STEP_GREEN = 50,
  parameter int MAX_WAIT   = 1000,
  parameter int CW         = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  traffic_phase_scheduler_if.master     bus
);

  typedef enum logic [1:0] {
    S_DECIDE = 2'd0,
    S_OFFER  = 2'd1,
    S_SERVE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_max_wait  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] c_green_max = {CW{1'b1}};

  state_t        r_state;
  logic [1:0]    r_last_dir;
  logic [CW-1:0] r_age [4];
  logic          r_grant_valid;
  logic [1:0]    r_grant_dir;
  logic [CW-1:0] r_grant_green;
  logic          r_grant_starved;
  logic          r_busy;

  logic [1:0]    w_level [4];
  logic [3:0]    w_age_inc;
  logic [1:0]    w_idx;
  logic [1:0]    w_best_dir;
  logic [1:0]    w_best_lvl;
  logic          w_any_starved;
  logic [1:0]    w_starved_dir;
  logic [1:0]    w_sel_dir;
  logic [1:0]    w_sel_level;
  logic [31:0]   w_green_wide;
  logic [CW-1:0] w_green;

  assign w_level[0] = bus.sensor_north;
  assign w_level[1] = bus.sensor_east;
  assign w_level[2] = bus.sensor_south;
  assign w_level[3] = bus.sensor_west;

  // An approach ages while it has traffic, unless it holds the current grant
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_age
    assign w_age_inc[gi] = (w_level[gi] != 2'd0) && (r_age[gi] != c_max_wait) &&
                           !((r_state != S_DECIDE) && (r_grant_dir == 2'(gi)));
  end

  // Walk the approaches in round-robin order: first starved one, and first with the highest level
  always_comb begin
    w_best_dir    = r_last_dir + 2'd1;
    w_best_lvl    = w_level[w_best_dir];
    w_any_starved = 1'b0;
    w_starved_dir = 2'd0;
    w_idx         = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_last_dir + 2'd1 + 2'(k);
      if (w_level[w_idx] > w_best_lvl) begin
        w_best_dir = w_idx;
        w_best_lvl = w_level[w_idx];
      end
      if (!w_any_starved && (r_age[w_idx] == c_max_wait)) begin
        w_any_starved = 1'b1;
        w_starved_dir = w_idx;
      end
    end
  end

  assign w_sel_dir    = w_any_starved ? w_starved_dir : w_best_dir;
  assign w_sel_level  = w_level[w_sel_dir];
  // Computed wide so that large levels saturate instead of wrapping
  assign w_green_wide = 32'(BASE_GREEN) + 32'(w_sel_level) * 32'(STEP_GREEN);
  assign w_green      = (w_green_wide > 32'(c_green_max)) ? c_green_max : w_green_wide[CW-1:0];

  // Phase FSM, registered grant fields and per-approach starvation ages
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_DECIDE;
      r_last_dir      <= 2'd3;
      r_grant_valid   <= 1'b0;
      r_grant_dir     <= 2'd0;
      r_grant_green   <= '0;
      r_grant_starved <= 1'b0;
      r_busy          <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_age_inc[i]) begin
          r_age[i] <= r_age[i] + CW'(1);
        end
      end
      case (r_state)
        S_DECIDE: begin
          r_grant_dir     <= w_sel_dir;
          r_grant_green   <= w_green;
          r_grant_starved <= w_any_starved;
          r_grant_valid   <= 1'b1;
          r_state         <= S_OFFER;
        end
        S_OFFER: begin
          if (r_grant_valid && bus.grant_ready) begin
            r_grant_valid      <= 1'b0;
            r_busy             <= 1'b1;
            r_last_dir         <= r_grant_dir;
            r_age[r_grant_dir] <= '0;
            r_state            <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (bus.phase_done) begin
            r_busy  <= 1'b0;
            r_state <= S_DECIDE;
          end
        end
        default: r_state <= S_DECIDE;
      endcase
    end
  end

  assign bus.grant_valid   = r_grant_valid;
  assign bus.grant_dir     = r_grant_dir;
  assign bus.grant_green   = r_grant_green;
  assign bus.grant_starved = r_grant_starved;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_traffic_phase_scheduler                                  |
// | Brief  : Table-driven bench for traffic_phase_scheduler: default,    |
// |          short-starvation and narrow/saturating configurations.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic       pdone = 1'b0;
  logic [1:0] s_n = 2'd0, s_e = 2'd0, s_s = 2'd0, s_w = 2'd0;
  int         sel = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler_if #(.CW(11)) if0 ();
  traffic_phase_scheduler_if #(.CW(11)) if1 ();
  traffic_phase_scheduler_if #(.CW(8))  if2 ();

  assign if0.sensor_north = s_n;  assign if0.sensor_east = s_e;
  assign if0.sensor_south = s_s;  assign if0.sensor_west = s_w;
  assign if1.sensor_north = s_n;  assign if1.sensor_east = s_e;
  assign if1.sensor_south = s_s;  assign if1.sensor_west = s_w;
  assign if2.sensor_north = s_n;  assign if2.sensor_east = s_e;
  assign if2.sensor_south = s_s;  assign if2.sensor_west = s_w;
  assign if0.grant_ready = ready && (sel == 0);
  assign if1.grant_ready = ready && (sel == 1);
  assign if2.grant_ready = ready && (sel == 2);
  assign if0.phase_done  = pdone && (sel == 0);
  assign if1.phase_done  = pdone && (sel == 1);
  assign if2.phase_done  = pdone && (sel == 2);

  traffic_phase_scheduler dut0 (.clk(clk), .reset(reset), .bus(if0));

  traffic_phase_scheduler #(.MAX_WAIT(20)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  traffic_phase_scheduler #(.BASE_GREEN(200), .STEP_GREEN(30), .MAX_WAIT(250), .CW(8))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic        o_valid, o_starved, o_busy;
  logic [1:0]  o_dir;
  logic [10:0] o_green;

  // Observe whichever instance is currently selected
  always_comb begin
    o_valid = if0.grant_valid; o_dir = if0.grant_dir; o_green = if0.grant_green;
    o_starved = if0.grant_starved; o_busy = if0.busy;
    if (sel == 1) begin
      o_valid = if1.grant_valid; o_dir = if1.grant_dir; o_green = if1.grant_green;
      o_starved = if1.grant_starved; o_busy = if1.busy;
    end else if (sel == 2) begin
      o_valid = if2.grant_valid; o_dir = if2.grant_dir; o_green = {3'b000, if2.grant_green};
      o_starved = if2.grant_starved; o_busy = if2.busy;
    end
  end

  typedef struct {
    logic       rst;
    int         sel;
    logic [1:0] n, e, s, w;
    int         serve;
    int         exp_dir;
    int         exp_green;
    int         exp_starved;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rst, input int sl, input logic [1:0] n, input logic [1:0] e,
                      input logic [1:0] s, input logic [1:0] w, input int serve,
                      input int dir, input int green, input int starved);
    vec_t v;
    v.rst = rst; v.sel = sl; v.n = n; v.e = e; v.s = s; v.w = w; v.serve = serve;
    v.exp_dir = dir; v.exp_green = green; v.exp_starved = starved;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_sens(input logic [1:0] n, input logic [1:0] e,
                          input logic [1:0] s, input logic [1:0] w);
    s_n = n; s_e = e; s_s = s; s_w = w;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; ready = 1'b0; pdone = 1'b0;
    step();
    check({tag, " rst valid"},   int'(o_valid), 0);
    check({tag, " rst dir"},     int'(o_dir), 0);
    check({tag, " rst green"},   int'(o_green), 0);
    check({tag, " rst starved"}, int'(o_starved), 0);
    check({tag, " rst busy"},    int'(o_busy), 0);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      step();
      n++;
    end
    if (!o_valid) check({tag, " valid timeout"}, 0, 1);
  endtask

  initial begin
    // Default config: plain rotation at level 01, then level-driven picks
    addv(1, 0, 2'd1, 2'd1, 2'd1, 2'd1, 5, 0, 150, 0);
    addv(0, 0, 2'd1, 2'd1, 2'd1, 2'd1, 5, 1, 150, 0);
    addv(0, 0, 2'd1, 2'd1, 2'd1, 2'd1, 5, 2, 150, 0);
    addv(0, 0, 2'd1, 2'd1, 2'd1, 2'd1, 5, 3, 150, 0);
    addv(0, 0, 2'd1, 2'd1, 2'd1, 2'd1, 5, 0, 150, 0);
    addv(0, 0, 2'd1, 2'd0, 2'd3, 2'd0, 5, 2, 250, 0);
    addv(0, 0, 2'd1, 2'd0, 2'd3, 2'd0, 5, 2, 250, 0);
    addv(0, 0, 2'd3, 2'd0, 2'd3, 2'd0, 5, 0, 250, 0);
    addv(0, 0, 2'd3, 2'd0, 2'd3, 2'd0, 5, 2, 250, 0);
    addv(0, 0, 2'd3, 2'd0, 2'd3, 2'd0, 5, 0, 250, 0);
    addv(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5, 1, 100, 0);
    addv(0, 0, 2'd1, 2'd2, 2'd1, 2'd1, 5, 1, 200, 0);
    addv(0, 0, 2'd2, 2'd2, 2'd0, 2'd0, 5, 0, 200, 0);
    // MAX_WAIT=20: 30-cycle phases starve the waiting approach
    addv(1, 1, 2'd0, 2'd1, 2'd3, 2'd0, 30, 2, 250, 0);
    addv(0, 1, 2'd0, 2'd1, 2'd3, 2'd0, 30, 1, 150, 1);
    addv(0, 1, 2'd0, 2'd1, 2'd3, 2'd0, 30, 2, 250, 1);
    // CW=8, base 200, step 30: level 3 saturates at 255
    addv(1, 2, 2'd3, 2'd3, 2'd3, 2'd3, 3, 0, 255, 0);
    addv(0, 2, 2'd1, 2'd0, 2'd0, 2'd0, 3, 0, 230, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].sel;
      if (vecs[i].rst) do_reset($sformatf("v%0d", i));
      set_sens(vecs[i].n, vecs[i].e, vecs[i].s, vecs[i].w);
      wait_valid($sformatf("v%0d", i));
      check($sformatf("v%0d dir", i),     int'(o_dir), vecs[i].exp_dir);
      check($sformatf("v%0d green", i),   int'(o_green), vecs[i].exp_green);
      check($sformatf("v%0d starved", i), int'(o_starved), vecs[i].exp_starved);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check($sformatf("v%0d busy", i), int'(o_busy), 1);
      repeat (vecs[i].serve - 1) step();
      pdone = 1'b1;
      step();
      pdone = 1'b0;
    end

    // Backpressure: grant holds while ready is low and sensors move
    sel = 0;
    set_sens(2'd1, 2'd1, 2'd1, 2'd1);
    do_reset("bp");
    wait_valid("bp");
    for (int c = 0; c < 10; c++) begin
      set_sens(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      step();
      check($sformatf("bp%0d valid", c), int'(o_valid), 1);
      check($sformatf("bp%0d dir", c),   int'(o_dir), 0);
      check($sformatf("bp%0d green", c), int'(o_green), 150);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("bp accept busy",  int'(o_busy), 1);
    check("bp accept valid", int'(o_valid), 0);

    // phase_done in SERVE: DECIDE next cycle, grant two cycles later
    pdone = 1'b1;
    step();
    pdone = 1'b0;
    set_sens(2'd1, 2'd1, 2'd1, 2'd1);
    check("pd +1 valid", int'(o_valid), 0);
    check("pd +1 busy",  int'(o_busy), 0);
    step();
    check("pd +2 valid", int'(o_valid), 1);
    check("pd +2 dir",   int'(o_dir), 1);

    // phase_done while offering is ignored
    pdone = 1'b1;
    step();
    pdone = 1'b0;
    check("offer pd valid", int'(o_valid), 1);
    check("offer pd busy",  int'(o_busy), 0);
    step();
    check("offer pd hold", int'(o_valid), 1);

    // phase_done in the accept cycle is ignored
    ready = 1'b1; pdone = 1'b1;
    step();
    ready = 1'b0; pdone = 1'b0;
    check("acc pd busy",  int'(o_busy), 1);
    repeat (3) step();
    check("acc pd still busy",  int'(o_busy), 1);
    check("acc pd still idle",  int'(o_valid), 0);

    // Reset mid-service drops the grant and restarts rotation at N
    do_reset("mid");
    wait_valid("mid");
    check("mid first dir",   int'(o_dir), 0);
    check("mid first green", int'(o_green), 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
